// File: rtl/thread_scheduler_pkg.sv
// Shared types for the SMT thread scheduler: core config subset, thread status, FSM states.
package thread_scheduler_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned NUM_THREADS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32, NUM_THREADS: 32'd4};

    typedef enum logic [1:0] {
        THREAD_HALTED  = 2'd0,
        THREAD_READY   = 2'd1,
        THREAD_WAITING = 2'd2
    } thread_status_t;

    typedef enum logic {
        SCHED_SELECT = 1'b0,
        SCHED_RUN    = 1'b1
    } sched_state_e;

    // Thread ID width; a single-thread core still carries a 1-bit ID.
    function automatic int unsigned tid_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Rotating-priority pick: first set request at or after start, wrapping, one-hot grant.
module thread_scheduler_rr_arbiter
    import thread_scheduler_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic             found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < int'(N); off++) begin
            idx = IDX_W'((int'(start) + off) % int'(N));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained SMT scheduler: picks the fetch thread, parks it on halt/miss/quantum expiry
// and drains pending wake-ups into the thread status store.
//
//  state        | meaning
//  SCHED_SELECT | no valid thread; scan for the next ready thread after cur_tid
//  SCHED_RUN    | cur_tid fetching; watch halt/switch/quantum events
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
    parameter int unsigned NUM_THREADS = CVA6Cfg.NUM_THREADS,
    parameter int unsigned QUANTUM     = 64,
    localparam int unsigned VLEN       = CVA6Cfg.VLEN,
    localparam int unsigned TID_W      = tid_w(NUM_THREADS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  thread_status_t       thread_status_i [NUM_THREADS],
    input  logic                 fetch_ready_i,
    input  logic                 switch_req_i,
    input  logic                 halt_req_i,
    input  logic [VLEN-1:0]      resume_pc_i,
    input  logic                 resume_req_i,
    input  logic [TID_W-1:0]     resume_id_i,
    output logic [TID_W-1:0]     active_thread_id_o,
    output logic                 thread_valid_o,
    output logic                 flush_o,
    output logic                 pc_write_o,
    output logic [TID_W-1:0]     pc_write_thread_id_o,
    output logic [VLEN-1:0]      pc_write_value_o,
    output logic                 status_update_o,
    output logic [TID_W-1:0]     status_update_id_o,
    output thread_status_t       status_value_o
);

    localparam int unsigned      CNT_W       = $clog2(QUANTUM + 1);
    localparam logic [TID_W-1:0] LAST_TID    = TID_W'(NUM_THREADS - 1);
    localparam logic [CNT_W-1:0] QUANTUM_CNT = CNT_W'(QUANTUM);

    sched_state_e         state_q, state_d;
    logic [TID_W-1:0]     cur_tid_q, cur_tid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_THREADS-1:0] pending_q, pending_d;

    logic [NUM_THREADS-1:0] ready_vec, waiting_vec, other_ready_vec;
    logic [NUM_THREADS-1:0] sel_grant, drain_grant;
    logic                   sel_found, drain_found, drain_take;
    logic [TID_W-1:0]       sel_start, sel_tid, drain_tid;

    logic                   ev_status_upd;
    thread_status_t         ev_status;

    always_comb begin
        ready_vec       = '0;
        waiting_vec     = '0;
        other_ready_vec = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            ready_vec[i]       = (thread_status_i[i] == THREAD_READY);
            waiting_vec[i]     = (thread_status_i[i] == THREAD_WAITING);
            other_ready_vec[i] = ready_vec[i] && (TID_W'(i) != cur_tid_q);
        end
    end

    // Scan starts just past the current thread so cur_tid is considered last.
    assign sel_start = (cur_tid_q == LAST_TID) ? '0 : cur_tid_q + 1'b1;

    thread_scheduler_rr_arbiter #(.N(NUM_THREADS), .IDX_W(TID_W)) u_sel_arb (
        .req   (ready_vec),
        .start (sel_start),
        .grant (sel_grant),
        .found (sel_found)
    );

    thread_scheduler_rr_arbiter #(.N(NUM_THREADS), .IDX_W(TID_W)) u_drain_arb (
        .req   (pending_q & waiting_vec),
        .start ('0),
        .grant (drain_grant),
        .found (drain_found)
    );

    always_comb begin
        sel_tid   = '0;
        drain_tid = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            if (sel_grant[i])   sel_tid   = TID_W'(i);
            if (drain_grant[i]) drain_tid = TID_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_tid_d     = cur_tid_q;
        cnt_d         = cnt_q;
        flush_o       = 1'b0;
        pc_write_o    = 1'b0;
        ev_status_upd = 1'b0;
        ev_status     = THREAD_READY;
        case (state_q)
            SCHED_SELECT: begin
                if (sel_found) begin
                    cur_tid_d = sel_tid;
                    cnt_d     = '0;
                    state_d   = SCHED_RUN;
                end
            end
            SCHED_RUN: begin
                if (fetch_ready_i && (cnt_q < QUANTUM_CNT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt_req_i) begin
                    pc_write_o    = 1'b1;
                    flush_o       = 1'b1;
                    ev_status_upd = 1'b1;
                    ev_status     = THREAD_HALTED;
                    state_d       = SCHED_SELECT;
                end else if (switch_req_i) begin
                    pc_write_o    = 1'b1;
                    flush_o       = 1'b1;
                    ev_status_upd = 1'b1;
                    ev_status     = THREAD_WAITING;
                    state_d       = SCHED_SELECT;
                end else if (cnt_q == QUANTUM_CNT) begin
                    if (|other_ready_vec) begin
                        pc_write_o = 1'b1;
                        flush_o    = 1'b1;
                        state_d    = SCHED_SELECT;
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = SCHED_SELECT;
        endcase
    end

    // Wake-ups only use the status port when no park update claims it.
    assign drain_take = drain_found && !ev_status_upd;

    always_comb begin
        pending_d = pending_q & waiting_vec;
        if (drain_take) begin
            pending_d = pending_d & ~drain_grant;
        end
        if (resume_req_i && !(drain_take && (drain_tid == resume_id_i))) begin
            pending_d[resume_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SCHED_SELECT;
            cur_tid_q <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_tid_q <= cur_tid_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign active_thread_id_o   = cur_tid_q;
    assign thread_valid_o       = (state_q == SCHED_RUN);
    assign pc_write_thread_id_o = cur_tid_q;
    assign pc_write_value_o     = resume_pc_i;
    assign status_update_o      = ev_status_upd || drain_take;
    assign status_update_id_o   = ev_status_upd ? cur_tid_q : drain_tid;
    assign status_value_o       = ev_status_upd ? ev_status : THREAD_READY;

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed scenarios then random traffic against a behavioural model.
module tb_thread_scheduler;
    import thread_scheduler_pkg::*;

    localparam int N = 4;
    localparam int Q = 4;
    localparam cva6_cfg_t CFG = '{VLEN: 32'd32, NUM_THREADS: 32'd4};

    logic           clk_i = 1'b0;
    logic           rst_ni;
    thread_status_t st [N];
    logic           fetch_ready, switch_req, halt_req, resume_req;
    logic [31:0]    resume_pc;
    logic [1:0]     resume_id;
    logic [1:0]     active_tid, pc_wr_id, su_id;
    logic           valid, flush, pc_wr, su;
    logic [31:0]    pc_wr_val;
    thread_status_t su_val;

    thread_scheduler #(.CVA6Cfg(CFG), .QUANTUM(Q)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .thread_status_i      (st),
        .fetch_ready_i        (fetch_ready),
        .switch_req_i         (switch_req),
        .halt_req_i           (halt_req),
        .resume_pc_i          (resume_pc),
        .resume_req_i         (resume_req),
        .resume_id_i          (resume_id),
        .active_thread_id_o   (active_tid),
        .thread_valid_o       (valid),
        .flush_o              (flush),
        .pc_write_o           (pc_wr),
        .pc_write_thread_id_o (pc_wr_id),
        .pc_write_value_o     (pc_wr_val),
        .status_update_o      (su),
        .status_update_id_o   (su_id),
        .status_value_o       (su_val)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: "running" flag, current thread, fetches since selection, set of pending wake-ups.
    bit m_run;
    int m_cur, m_cnt;
    bit m_pend [N];

    task automatic model_reset();
        m_run = 0;
        m_cur = 0;
        m_cnt = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic step(input bit fr, input bit sw, input bit hl, input logic [31:0] pc,
                        input bit rr, input int rid);
        bit e_flush, e_pcw, e_su, n_run;
        int e_su_id, n_cur, n_cnt, others, drained;
        thread_status_t e_su_val;
        bit n_pend [N];
        fetch_ready = fr; switch_req = sw; halt_req = hl;
        resume_pc = pc; resume_req = rr; resume_id = 2'(rid);
        #1;
        e_flush = 0; e_pcw = 0; e_su = 0; e_su_id = 0; e_su_val = THREAD_READY;
        n_run = m_run; n_cur = m_cur; n_cnt = m_cnt;
        if (!m_run) begin
            for (int k = 1; k <= N; k++) begin
                if (!n_run && st[(m_cur + k) % N] == THREAD_READY) begin
                    n_run = 1; n_cur = (m_cur + k) % N; n_cnt = 0;
                end
            end
        end else begin
            if (fr && m_cnt < Q) n_cnt = m_cnt + 1;
            if (hl || sw) begin
                e_pcw = 1; e_flush = 1; e_su = 1; e_su_id = m_cur; n_run = 0;
                e_su_val = hl ? THREAD_HALTED : THREAD_WAITING;
            end else if (m_cnt == Q) begin
                others = 0;
                for (int i = 0; i < N; i++) if (i != m_cur && st[i] == THREAD_READY) others++;
                if (others > 0) begin
                    e_pcw = 1; e_flush = 1; n_run = 0;
                end else begin
                    n_cnt = 0;
                end
            end
        end
        drained = -1;
        if (!e_su) begin
            for (int p = 0; p < N; p++)
                if (drained < 0 && m_pend[p] && st[p] == THREAD_WAITING) drained = p;
            if (drained >= 0) begin
                e_su = 1; e_su_id = drained; e_su_val = THREAD_READY;
            end
        end
        for (int p = 0; p < N; p++) begin
            n_pend[p] = m_pend[p] && st[p] == THREAD_WAITING && p != drained;
            if (rr && p == rid && p != drained) n_pend[p] = 1;
        end

        check_eq("valid", 64'(valid), 64'(m_run));
        check_eq("active_tid", 64'(active_tid), 64'(m_cur));
        check_eq("flush", 64'(flush), 64'(e_flush));
        check_eq("pc_write", 64'(pc_wr), 64'(e_pcw));
        if (e_pcw) begin
            check_eq("pc_write_id", 64'(pc_wr_id), 64'(m_cur));
            check_eq("pc_write_value", 64'(pc_wr_val), 64'(pc));
        end
        check_eq("status_update", 64'(su), 64'(e_su));
        if (e_su) begin
            check_eq("status_id", 64'(su_id), 64'(e_su_id));
            check_eq("status_value", 64'(su_val), 64'(e_su_val));
        end

        @(posedge clk_i);
        #1;
        if (e_su) st[e_su_id] = e_su_val;
        m_run = n_run; m_cur = n_cur; m_cnt = n_cnt;
        foreach (m_pend[i]) m_pend[i] = n_pend[i];
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle with the previous inputs still applied.
    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_tid", 64'(active_tid), 64'd0);
        check_eq("rst_flush", 64'(flush), 64'd0);
        check_eq("rst_pc_write", 64'(pc_wr), 64'd0);
        check_eq("rst_status_update", 64'(su), 64'd0);
        fetch_ready = 0; switch_req = 0; halt_req = 0; resume_req = 0;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int rid;
        rst_ni = 1'b0;
        fetch_ready = 0; switch_req = 0; halt_req = 0; resume_req = 0;
        resume_pc = '0; resume_id = '0;
        st[0] = THREAD_READY;
        for (int i = 1; i < N; i++) st[i] = THREAD_HALTED;
        @(negedge clk_i);
        do_reset();

        // one SELECT cycle, then tid0 valid
        idle(4);
        // quantum expiry with a second ready thread
        st[1] = THREAD_READY;
        for (int i = 0; i < 9; i++) step(1, 0, 0, 32'h1000 + 32'(i), 0, 0);
        // miss on tid1 parks it waiting; tid0 reselected
        step(0, 1, 0, 32'h8000_0040, 0, 0);
        idle(3);
        // wake tid1 in the same cycle tid0 halts
        step(0, 0, 1, 32'h8000_0100, 1, 1);
        idle(4);
        // park the last runner: everything halted, then wake a waiting thread2
        step(0, 0, 1, 32'h8000_0200, 0, 0);
        idle(4);
        st[2] = THREAD_WAITING;
        step(0, 0, 0, 32'h0, 1, 2);
        idle(4);
        // resume for the running thread during its own park ends it ready
        step(1, 1, 0, 32'h8000_0300, 1, 2);
        idle(4);
        // reset with a pending wake-up outstanding
        st[3] = THREAD_WAITING;
        step(1, 0, 0, 32'h0, 1, 3);
        do_reset();
        idle(5);

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                rid = int'($urandom_range(0, N - 1));
                if (st[rid] == THREAD_HALTED) st[rid] = THREAD_WAITING;
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 14) == 0,
                     $urandom_range(0, 39) == 0, $urandom,
                     $urandom_range(0, 4) == 0, int'($urandom_range(0, N - 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
